// File: rtl/texture_pkg.sv
// rtl/texture_pkg.sv - texture size codes, texel-count table and sink FSM states
package texture_pkg;

  typedef enum logic [1:0] {
    SZ_32  = 2'd0,
    SZ_64  = 2'd1,
    SZ_128 = 2'd2,
    SZ_256 = 2'd3
  } tex_size_e;

  // Texels per texture for each size code: (32 << size) squared.
  localparam logic [16:0] TEX_COUNT [4] = '{17'd1024, 17'd4096, 17'd16384, 17'd65536};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STREAM    = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_SWAP_WAIT = 2'd3
  } sink_state_e;

endpackage

// File: rtl/texture_stream_sink.sv
// rtl/texture_stream_sink.sv - texel stream to texture RAM writer; TEXTURE_DOUBLE_BUFFER_EN selects double-buffered banks
module texture_stream_sink
  import texture_pkg::*;
#(
  parameter int TEXEL_WIDTH = 16,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic                   s_texture_axis_tvalid,
  output logic                   s_texture_axis_tready,
  input  logic                   s_texture_axis_tlast,
  input  logic [TEXEL_WIDTH-1:0] s_texture_axis_tdata,
  input  logic [1:0]             confTextureSize,
  input  logic                   rasterizerRunning,
  input  logic                   pixelInPipeline,
  output logic                   mem_we,
  output logic [ADDR_WIDTH:0]    mem_waddr,
  output logic [TEXEL_WIDTH-1:0] mem_wdata,
  output logic                   sampleBank,
  output logic [1:0]             confTexSizeActive,
  output logic                   textureValid,
  output logic                   errShort,
  output logic                   errLong
);

  // One extra bit so the largest texel count compares without wrapping.
  localparam int IDX_W = ADDR_WIDTH + 1;

  sink_state_e            state_q;
  logic                   rst_done_q;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       idx_d;
  logic [IDX_W-1:0]       expected_q;
  logic [1:0]             size_q;
  logic                   sample_bank_q;
  logic [1:0]             size_active_q;
  logic                   tex_valid_q;
  logic                   err_short_q;
  logic                   err_long_q;
  logic                   mem_we_q;
  logic [ADDR_WIDTH:0]    mem_waddr_q;
  logic [TEXEL_WIDTH-1:0] mem_wdata_q;
  logic                   ready_st;
  logic                   accept;
  logic                   raster_busy;
  logic                   write_bank;

  assign raster_busy = rasterizerRunning | pixelInPipeline;
  assign idx_d       = idx_q + 1'b1;

`ifdef TEXTURE_DOUBLE_BUFFER_EN
  assign write_bank = ~sample_bank_q;
`else
  assign write_bank = 1'b0;
`endif

  // Ready is a pure function of state (plus raster activity in single-bank IDLE).
  always_comb begin
    ready_st = 1'b0;
    case (state_q)
`ifdef TEXTURE_DOUBLE_BUFFER_EN
      ST_IDLE:      ready_st = 1'b1;
`else
      ST_IDLE:      ready_st = ~raster_busy;
`endif
      ST_STREAM:    ready_st = 1'b1;
      ST_DRAIN:     ready_st = 1'b1;
      ST_SWAP_WAIT: ready_st = 1'b0;
      default:      ready_st = 1'b0;
    endcase
  end

  assign s_texture_axis_tready = rst_done_q & ready_st;
  assign accept                = s_texture_axis_tvalid & s_texture_axis_tready;

  // Upload FSM: beat counting, RAM write registers, bank swap and sticky errors.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      rst_done_q    <= 1'b0;
      idx_q         <= '0;
      expected_q    <= '0;
      size_q        <= 2'd0;
      sample_bank_q <= 1'b0;
      size_active_q <= 2'd0;
      tex_valid_q   <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_waddr_q   <= '0;
      mem_wdata_q   <= '0;
    end else begin
      rst_done_q <= 1'b1;
      mem_we_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            size_q      <= confTextureSize;
            expected_q  <= IDX_W'(TEX_COUNT[confTextureSize]);
            idx_q       <= IDX_W'(1);
            mem_we_q    <= 1'b1;
            mem_waddr_q <= {write_bank, {ADDR_WIDTH{1'b0}}};
            mem_wdata_q <= s_texture_axis_tdata;
`ifndef TEXTURE_DOUBLE_BUFFER_EN
            tex_valid_q <= 1'b0;
`endif
            // The smallest texture is far larger than one beat, so an early tlast is always short.
            if (s_texture_axis_tlast) begin
              err_short_q <= 1'b1;
            end else begin
              state_q <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (accept) begin
            mem_we_q    <= 1'b1;
            mem_waddr_q <= {write_bank, idx_q[ADDR_WIDTH-1:0]};
            mem_wdata_q <= s_texture_axis_tdata;
            idx_q       <= idx_d;
            if (s_texture_axis_tlast) begin
              if (idx_d == expected_q) begin
                state_q <= ST_SWAP_WAIT;
              end else begin
                err_short_q <= 1'b1;
                state_q     <= ST_IDLE;
              end
            end else if (idx_d == expected_q) begin
              err_long_q <= 1'b1;
              state_q    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (accept && s_texture_axis_tlast) begin
            state_q <= ST_IDLE;
          end
        end
        ST_SWAP_WAIT: begin
`ifdef TEXTURE_DOUBLE_BUFFER_EN
          if (!raster_busy) begin
            sample_bank_q <= ~sample_bank_q;
            size_active_q <= size_q;
            tex_valid_q   <= 1'b1;
            state_q       <= ST_IDLE;
          end
`else
          size_active_q <= size_q;
          tex_valid_q   <= 1'b1;
          state_q       <= ST_IDLE;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_we            = mem_we_q;
  assign mem_waddr         = mem_waddr_q;
  assign mem_wdata         = mem_wdata_q;
  assign sampleBank        = sample_bank_q;
  assign confTexSizeActive = size_active_q;
  assign textureValid      = tex_valid_q;
  assign errShort          = err_short_q;
  assign errLong           = err_long_q;

endmodule

// File: tb/tb_texture_stream_sink.sv
// tb/tb_texture_stream_sink.sv - randomized bench for texture_stream_sink against a texture-level model
module tb_texture_stream_sink;

`ifdef TEXTURE_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        resetn;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [15:0] tdata;
  logic [1:0]  conf_size;
  logic        raster_running;
  logic        pixel_in_pipe;
  logic        mem_we;
  logic [16:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic        sample_bank;
  logic [1:0]  size_active;
  logic        tex_valid;
  logic        err_short;
  logic        err_long;

  int n_cmp = 0;
  int n_mis = 0;

  // Expected RAM writes as {bank, index, texel}.
  logic [32:0] exp_q[$];

  // Texture-level model state.
  logic       m_bank;
  logic [1:0] m_size;
  logic       m_valid;
  logic       m_es;
  logic       m_el;

  always #5 aclk = ~aclk;

  texture_stream_sink dut (
    .aclk                  (aclk),
    .resetn                (resetn),
    .s_texture_axis_tvalid (tvalid),
    .s_texture_axis_tready (tready),
    .s_texture_axis_tlast  (tlast),
    .s_texture_axis_tdata  (tdata),
    .confTextureSize       (conf_size),
    .rasterizerRunning     (raster_running),
    .pixelInPipeline       (pixel_in_pipe),
    .mem_we                (mem_we),
    .mem_waddr             (mem_waddr),
    .mem_wdata             (mem_wdata),
    .sampleBank            (sample_bank),
    .confTexSizeActive     (size_active),
    .textureValid          (tex_valid),
    .errShort              (err_short),
    .errLong               (err_long)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every RAM write must match the next expected write, in order.
  always @(negedge aclk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("write_expected", 64'(exp_q.size()), 64'd1);
      end else begin
        check_eq("write", {31'd0, mem_waddr, mem_wdata}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic model_reset();
    m_bank  = 1'b0;
    m_size  = 2'd0;
    m_valid = 1'b0;
    m_es    = 1'b0;
    m_el    = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_tready"}, 64'(tready), 64'd0);
    check_eq({tag, "_we"}, 64'(mem_we), 64'd0);
    check_eq({tag, "_waddr"}, 64'(mem_waddr), 64'd0);
    check_eq({tag, "_bank"}, 64'(sample_bank), 64'd0);
    check_eq({tag, "_size"}, 64'(size_active), 64'd0);
    check_eq({tag, "_valid"}, 64'(tex_valid), 64'd0);
    check_eq({tag, "_errs"}, {62'd0, err_short, err_long}, 64'd0);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    check_eq({tag, "_bank"}, 64'(sample_bank), 64'(m_bank));
    check_eq({tag, "_valid"}, 64'(tex_valid), 64'(m_valid));
    if (m_valid) check_eq({tag, "_size"}, 64'(size_active), 64'(m_size));
    check_eq({tag, "_short"}, 64'(err_short), 64'(m_es));
    check_eq({tag, "_long"}, 64'(err_long), 64'(m_el));
    check_eq({tag, "_idle_ready"}, 64'(tready), 64'd1);
  endtask

  // Sends nbeats texels (tlast on the final one) and updates the model from the upload's outcome.
  task automatic upload(input string tag, input int size, input int nbeats, input int gap_div,
                        input int hold, input int abort_at);
    int          n;
    logic        wb;
    logic [15:0] d;
    bit          accepted;
    n  = (32 << size) * (32 << size);
    wb = DB ? ~m_bank : 1'b0;
    @(negedge aclk);
    for (int k = 0; k < nbeats; k++) begin
      if (k == abort_at) begin
        resetn = 1'b0;
        tvalid = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check_reset_values({tag, "_midreset"});
        model_reset();
        resetn = 1'b1;
        @(negedge aclk);
        return;
      end
      if (gap_div > 0 && $urandom_range(gap_div - 1) == 0) begin
        tvalid = 1'b0;
        @(negedge aclk);
      end
      if (k == nbeats - 1 && hold > 0) raster_running = 1'b1;
      d         = 16'($urandom);
      tvalid    = 1'b1;
      tdata     = d;
      tlast     = (k == nbeats - 1);
      conf_size = (k == 0) ? 2'(size) : 2'($urandom);
      accepted  = 1'b0;
      for (int t = 0; t < 64; t++) begin
        #1;
        if (tready === 1'b1) begin
          @(posedge aclk);
          accepted = 1'b1;
          break;
        end
        @(negedge aclk);
      end
      if (!accepted) begin
        check_eq({tag, "_accept_timeout"}, 64'd0, 64'd1);
        tvalid = 1'b0;
        return;
      end
      if (k < n) exp_q.push_back({wb, 16'(k), d});
      if (k == 0 && !DB) m_valid = 1'b0;
      @(negedge aclk);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (nbeats == n) begin
      if (hold > 0) begin
        for (int h = 0; h < hold; h++) begin
          #1;
          check_eq({tag, "_hold_tready"}, 64'(tready), 64'd0);
          if (DB) check_eq({tag, "_hold_bank"}, 64'(sample_bank), 64'(m_bank));
          @(negedge aclk);
        end
        raster_running = 1'b0;
        @(negedge aclk);
        check_eq({tag, "_swap_after_release"}, 64'(sample_bank), 64'(m_bank ^ DB));
      end
      m_bank  = m_bank ^ DB;
      m_valid = 1'b1;
      m_size  = 2'(size);
    end else if (nbeats < n) begin
      m_es = 1'b1;
    end else begin
      m_el = 1'b1;
    end
    repeat (3) @(negedge aclk);
    check_state(tag);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    tvalid         = 1'b0;
    tlast          = 1'b0;
    tdata          = '0;
    conf_size      = 2'd0;
    raster_running = 1'b0;
    pixel_in_pipe  = 1'b0;
    model_reset();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_values("reset");
    resetn = 1'b1;
    repeat (2) @(negedge aclk);

    upload("full32", 0, 1024, 4, 0, -1);
    upload("full64_hold", 1, 4096, 0, 50, -1);
    upload("short10", 0, 10, 0, 0, -1);
    upload("after_short", 0, 1024, 8, 0, -1);
    upload("long1030", 0, 1030, 0, 0, -1);
    upload("abort500", 0, 1024, 0, 0, 500);
    upload("restart", 0, 1024, 0, 0, -1);
    upload("full256", 3, 65536, 32, 0, -1);
    for (int r = 0; r < 3; r++) begin
      int nb;
      nb = 1024 + int'($urandom_range(8)) - 4;
      upload("rand", 0, nb, 3, 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
